sync_fifo_rr_drain_arbiter: RTL
===============================

// Module: sync_fifo_rr_drain_arbiter
// PURPOSE
//  Drains NUM_SRC sync_fifo_fwft_with_clear instances onto one valid/ready output stream.
//  Round-robin arbitration with a configurable burst length (max consecutive grants per source).
//  Sequences per-queue flushes onto the FIFO i_clr pins.
//  Sits between per-channel ingress FIFOs and a shared downstream consumer.
// PARAMETERS
//  NUM_SRC    4  number of source FIFOs, >=1
//  DATA_WIDTH 8  FIFO word width
//  BURST_LEN  1  max consecutive pops from one source before rotating, >=1
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   async reset, active low
//  i_fifo_empty   in   NUM_SRC             o_empty of each source FIFO
//  i_fifo_rd_data in   NUM_SRC*DATA_WIDTH  FWFT head word of each FIFO, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//  o_fifo_rd_en   out  NUM_SRC             one-hot pop strobe to the granted FIFO
//  i_flush        in   NUM_SRC             per-source flush request, one-cycle pulse
//  o_fifo_clr     out  NUM_SRC             i_clr to each FIFO
//  o_valid        out  1                   output word valid
//  o_data         out  DATA_WIDTH          output word
//  o_src_id       out  SRC_W               index of the source that produced o_data
//  i_ready        in   1                   consumer accepts when o_valid & i_ready
// BEHAVIOUR
//  Reset values:
//   - Output register: o_valid=0, o_data=0, o_src_id=0.
//   - Arbiter state: last-grant pointer = NUM_SRC-1, so source 0 wins first; burst_cnt=0.
//   - o_fifo_rd_en=0 and o_fifo_clr=0 while rst_n is low.
//  Widths: SRC_W = (NUM_SRC>1) ? $clog2(NUM_SRC) : 1; burst_cnt width = $clog2(BURST_LEN+1).
//  Candidates: cand[k] = !i_fifo_empty[k] & !i_flush[k].
//  Pop condition: can_pop = (|cand) & (!o_valid | i_ready).
//   - Full throughput is one word per cycle with i_ready held high.
//  Grant selection, only when can_pop:
//   - Stay: if last-grant source L is a candidate and burst_cnt < BURST_LEN, grant L and increment burst_cnt.
//   - Rotate: otherwise grant the first candidate searching L+1, L+2, ... with modulo NUM_SRC wrap.
//     Set L to the winner and burst_cnt=1.
//  Pop strobe: o_fifo_rd_en = onehot(grant) & {NUM_SRC{can_pop}}.
//   - Combinational, so the FWFT pop happens on the same edge as the capture.
//   - Never asserted toward an empty or flushing FIFO.
//  Capture: on a pop edge, o_data <= the granted head word, o_src_id <= grant, o_valid <= 1.
//  Latency: FIFO non-empty at cycle t (output free) -> o_valid high at t+1.
//  Output drain: o_valid & i_ready with no pop -> o_valid <= 0; o_data is held, not cleared.
//  Stall: while o_valid & !i_ready, o_valid, o_data and o_src_id are stable and no pops occur.
//  Flush handling:
//   - o_fifo_clr = i_flush & {NUM_SRC{rst_n}}, same cycle.
//   - A flushed source is excluded from that cycle's arbitration.
//   - A word already in the output register is unaffected by a flush of its source and is still delivered.
//   - If the flushed source is L, burst_cnt <= 0, which forces a rotate on its next grant.
//  Simultaneous events:
//   - Accept plus new pop in the same cycle gives a back-to-back word with no bubble.
//   - Flush of every candidate in one cycle gives no pop.
//  NUM_SRC=1: degenerates to a registered FWFT-to-valid/ready stage; burst logic is inert.
// STRUCTURE
//  Package sync_fifo_arb_pkg:
//   - function src_w(n), returning the SRC_W rule above.
//   - function rr_next(req, last), a round-robin search helper.
//  Sub-module rr_priority_picker (NUM_SRC):
//   - Combinational.
//   - Inputs req[NUM_SRC], last[SRC_W]; outputs gnt_onehot, gnt_idx, any.
//  Top level holds the last/burst_cnt registers, the output register and the flush masking.
// TESTING
//  Formal: a Jasper scoreboard per source; words out with o_src_id==k equal words in to FIFO k, in order.
//  Formal assertions:
//   - $onehot0(o_fifo_rd_en).
//   - o_fifo_rd_en[k] -> !i_fifo_empty[k] & !i_flush[k].
//   - Output is stable under stall.
//  Directed scenarios:
//   - Post reset, all FIFOs hold 3 words, i_ready=1, BURST_LEN=1 -> o_src_id sequence 0,1,2,3,0,1,... with o_valid continuously high.
//   - Same stimulus with BURST_LEN=2 -> o_src_id sequence 0,0,1,1,2,2,3,3,0,...
//   - Only source 2 non-empty, i_ready=0 for 5 cycles -> exactly one pop, o_data held 5 cycles; i_ready=1 -> next pop the same cycle.
//   - i_flush[1] while source 1 is the granted candidate -> o_fifo_clr[1]=1 and o_fifo_rd_en[1]=0 that cycle; the held word from source 1 is still delivered.
//   - Sources 0 and 3 non-empty, last=3, BURST_LEN=1 -> next grant is 0 (wrap), then 3.
//   - rst_n low mid-stream with o_valid=1 -> o_valid=0, rd_en=0 and clr=0 immediately; the first grant after release is source 0.

Source files
------------

// File: rtl/sync_fifo_rr_drain_arbiter_pkg.sv
// Shared widths and round-robin helpers for the FIFO drain arbiter.
// Latency: none (functions only).
// Backpressure: n/a.
package sync_fifo_arb_pkg;

    // Upper bound on source count supported by the search helper.
    localparam int MAX_SRC = 32;

    // Width of a source index; a single source still needs one bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester after 'last', wrapping modulo n; 'last' itself is checked last.
    // Returns 'last' when nothing requests.
    function automatic int rr_next(input logic [MAX_SRC-1:0] req, input int last, input int n);
        int   pick;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_SRC; i++) begin
            if (!found && (i <= n) && req[(last + i) % n]) begin
                pick  = (last + i) % n;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_fifo_rr_drain_arbiter_if.sv
// Bundle of FIFO-side and consumer-side signals of the drain arbiter.
// Latency: none (wiring only).
// Backpressure: i_ready from the consumer, o_fifo_rd_en toward the FIFOs.
interface sync_fifo_rr_drain_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_W = sync_fifo_arb_pkg::src_w(NUM_SRC);

    logic [NUM_SRC-1:0]            i_fifo_empty;
    logic [NUM_SRC*DATA_WIDTH-1:0] i_fifo_rd_data;
    logic [NUM_SRC-1:0]            o_fifo_rd_en;
    logic [NUM_SRC-1:0]            i_flush;
    logic [NUM_SRC-1:0]            o_fifo_clr;
    logic                          o_valid;
    logic [DATA_WIDTH-1:0]         o_data;
    logic [SRC_W-1:0]              o_src_id;
    logic                          i_ready;

    // Arbiter side.
    modport master (
        input  i_fifo_empty, i_fifo_rd_data, i_flush, i_ready,
        output o_fifo_rd_en, o_fifo_clr, o_valid, o_data, o_src_id
    );

    // FIFO bank and consumer side.
    modport slave (
        output i_fifo_empty, i_fifo_rd_data, i_flush, i_ready,
        input  o_fifo_rd_en, o_fifo_clr, o_valid, o_data, o_src_id
    );

endinterface

// File: rtl/sync_fifo_rr_drain_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first requester after 'last', with wrap.
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is used.
module rr_priority_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int SRC_W  = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);

    logic [MAX_SRC-1:0] req_ext;

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req;
        any                    = |req;
        gnt_idx                = SRC_W'(rr_next(req_ext, int'(last), NUM_SRC));
        gnt_onehot             = '0;
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_rr_drain_arbiter.sv
// Drains NUM_SRC FWFT FIFOs round-robin (bursts up to BURST_LEN) into one registered valid/ready stream; sequences flushes.
// Latency: FIFO non-empty at cycle t with a free output -> o_valid at t+1; one word per cycle sustained.
// Backpressure: no pops while o_valid & !i_ready; output register holds steady until accepted.
module sync_fifo_rr_drain_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 1,
    localparam int SRC_W     = src_w(NUM_SRC),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sync_fifo_rr_drain_arbiter_if.master  bus
);

    logic [SRC_W-1:0]      last_q;
    logic [CNT_W-1:0]      burst_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SRC_W-1:0]      src_q;

    logic [NUM_SRC-1:0]    cand;
    logic [NUM_SRC-1:0]    rot_onehot;
    logic [SRC_W-1:0]      rot_idx;
    logic                  rot_any;
    logic                  stay;
    logic                  can_pop;
    logic [SRC_W-1:0]      grant;
    logic [NUM_SRC-1:0]    grant_onehot;
    logic [DATA_WIDTH-1:0] head;

    // A flushing FIFO is never a candidate, so it cannot be popped while it clears.
    assign cand = ~bus.i_fifo_empty & ~bus.i_flush;

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req        (cand),
        .last       (last_q),
        .gnt_onehot (rot_onehot),
        .gnt_idx    (rot_idx),
        .any        (rot_any)
    );

    // Grant selection: continue an open burst on the last winner, otherwise rotate.
    // burst_q==0 means no open burst (after reset or after the last winner was flushed).
    always_comb begin
        stay         = cand[last_q] && (burst_q != '0) && (burst_q < CNT_W'(BURST_LEN));
        can_pop      = rot_any && (!valid_q || bus.i_ready);
        grant        = stay ? last_q : rot_idx;
        grant_onehot = rot_onehot;
        if (stay) begin
            grant_onehot         = '0;
            grant_onehot[last_q] = 1'b1;
        end
        head = bus.i_fifo_rd_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pop and clear strobes are combinational so the FWFT pop lands on the capture edge.
    assign bus.o_fifo_rd_en = grant_onehot & {NUM_SRC{can_pop & rst_n}};
    assign bus.o_fifo_clr   = bus.i_flush & {NUM_SRC{rst_n}};

    // Arbiter pointer and burst length bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= SRC_W'(NUM_SRC - 1);
            burst_q <= '0;
        end else if (can_pop) begin
            if (stay) begin
                burst_q <= burst_q + CNT_W'(1);
            end else begin
                last_q  <= rot_idx;
                burst_q <= CNT_W'(1);
            end
        end else if (bus.i_flush[last_q]) begin
            burst_q <= '0;
        end
    end

    // Output register: load on pop, drop valid on accept-without-pop, data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else if (can_pop) begin
            valid_q <= 1'b1;
            data_q  <= head;
            src_q   <= grant;
        end else if (valid_q && bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_data   = data_q;
    assign bus.o_src_id = src_q;

endmodule
